// File: rtl/shift_line_arbiter_if.sv
// shift_line_arbiter_if: requester-side handshake and response bundle
// for shift_line_arbiter (two byte requesters, one shared response bus).
interface shift_line_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp0_valid;
  logic             rsp1_valid;

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  rsp_data, rsp0_valid, rsp1_valid
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    output req0_ready, req1_ready,
    output rsp_data, rsp0_valid, rsp1_valid
  );
endinterface

// File: rtl/shift_line_arbiter.sv
// shift_line_arbiter: shares one DEPTH-stage delay line between two requesters.
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module shift_line_arbiter #(
  parameter int DEPTH        = 5,
  parameter int WIDTH        = 8,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_line_arbiter_if.slave  bus,
  output logic [WIDTH-1:0]     sr_din,
  input  logic [WIDTH-1:0]     sr_dout,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_INFLIGHT);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;
  logic [DEPTH-1:0] sh_v;
  logic [DEPTH-1:0] sh_t;

  logic elig0;
  logic elig1;
  logic tie0;
  logic xfer0;
  logic xfer1;
  logic xfer;
  logic out_v;
  logic rsp0v;
  logic rsp1v;
  logic empty;

  assign elig0 = (state == RUN) && !flush
               && (cnt0 < MAXC);
  assign elig1 = (state == RUN) && !flush
               && (cnt1 < MAXC);

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign tie0 = 1'b1;
`else
  // last=1 means requester 1 was granted last, so 0 wins a tie
  logic last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (xfer) begin
      last <= xfer1;
    end
  end

  assign tie0 = last;
`endif

  // ready never looks at its own valid, only the rival's
  assign bus.req0_ready = elig0
    && (!(elig1 && bus.req1_valid) || tie0);
  assign bus.req1_ready = elig1
    && (!(elig0 && bus.req0_valid) || !tie0);

  assign xfer0 = bus.req0_valid && bus.req0_ready;
  assign xfer1 = bus.req1_valid && bus.req1_ready;
  assign xfer  = xfer0 || xfer1;

  always_comb begin
    sr_din = '0;
    unique case (1'b1)
      xfer0:   sr_din = bus.req0_data;
      xfer1:   sr_din = bus.req1_data;
      default: sr_din = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_v <= '0;
      sh_t <= '0;
    end else begin
      sh_v <= {sh_v[DEPTH-2:0], xfer};
      sh_t <= {sh_t[DEPTH-2:0], xfer1};
    end
  end

  assign out_v          = sh_v[DEPTH-1];
  assign rsp0v          = out_v && !sh_t[DEPTH-1];
  assign rsp1v          = out_v && sh_t[DEPTH-1];
  assign bus.rsp_data   = out_v ? sr_dout : '0;
  assign bus.rsp0_valid = rsp0v;
  assign bus.rsp1_valid = rsp1v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0 <= '0;
    end else begin
      unique case ({xfer0, rsp0v})
        2'b10:   cnt0 <= cnt0 + 1'b1;
        2'b01:   cnt0 <= cnt0 - 1'b1;
        default: cnt0 <= cnt0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt1 <= '0;
    end else begin
      unique case ({xfer1, rsp1v})
        2'b10:   cnt1 <= cnt1 + 1'b1;
        2'b01:   cnt1 <= cnt1 - 1'b1;
        default: cnt1 <= cnt1;
      endcase
    end
  end

  assign empty = !(|sh_v)
              && (cnt0 == '0) && (cnt1 == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (flush)  state_nxt = DRAIN;
      DRAIN:   if (empty)  state_nxt = DONE;
      DONE:    if (!flush) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign flush_done = (state == DONE);
  assign busy       = |sh_v;

endmodule
